// File: rtl/trap_csr_sequencer_pkg.sv
// trap_csr_sequencer_pkg: CSR addresses, mstatus field positions, state encoding and mstatus update helpers
// Optional feature macro: TRAP_MTVAL_EN (adds the mtval write state)
package trap_csr_sequencer_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_LO   = 11;
    localparam int MPP_HI   = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T_MEPC,
        S_T_MCAUSE,
`ifdef TRAP_MTVAL_EN
        S_T_MTVAL,
`endif
        S_T_MSTATUS,
        S_M_MSTATUS
    } state_t;

    // Trap entry: stack MIE into MPIE, disable interrupts, previous privilege = M
    function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r                = s;
        r[MPIE_BIT]      = s[MIE_BIT];
        r[MIE_BIT]       = 1'b0;
        r[MPP_HI:MPP_LO] = 2'b11;
        return r;
    endfunction

    // mret: restore MIE from MPIE and set MPIE
    function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r           = s;
        r[MIE_BIT]  = s[MPIE_BIT];
        r[MPIE_BIT] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/trap_csr_sequencer.sv
// trap_csr_sequencer: serialises trap-entry/mret CSR writes onto the single CSR write port, arbitrating against pipeline CSR writes
// Optional feature macro: TRAP_MTVAL_EN (trap_tval port and mtval write)
module trap_csr_sequencer
    import trap_csr_sequencer_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pipe_csr_we,
    input  logic [CSR_AW-1:0] pipe_csr_addr,
    input  logic [XLEN-1:0]   pipe_csr_wdata,
    output logic              pipe_ready,
    input  logic              trap_req,
    input  logic [XLEN-1:0]   trap_epc,
    input  logic [XLEN-1:0]   trap_cause,
`ifdef TRAP_MTVAL_EN
    input  logic [XLEN-1:0]   trap_tval,
`endif
    input  logic              mret_req,
    input  logic [XLEN-1:0]   mstatus_i,
    output logic              trap_ack,
    output logic              mret_ack,
    output logic              trap_done,
    output logic              mret_done,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_addr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              busy,
    output logic              pipe_drop_err
);

    state_t            r_state;
    logic [XLEN-1:0]   r_epc;
    logic [XLEN-1:0]   r_cause;
`ifdef TRAP_MTVAL_EN
    logic [XLEN-1:0]   r_tval;
`endif
    logic [XLEN-1:0]   r_mstatus;
    logic              r_drop_err;
    logic              w_idle;

    assign w_idle = (r_state == S_IDLE);

    // Sequence state, latched trap operands, mstatus snapshot and sticky drop flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_epc      <= '0;
            r_cause    <= '0;
`ifdef TRAP_MTVAL_EN
            r_tval     <= '0;
`endif
            r_mstatus  <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (!w_idle && pipe_csr_we)
                r_drop_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (trap_req) begin
                        r_epc   <= trap_epc;
                        r_cause <= trap_cause;
`ifdef TRAP_MTVAL_EN
                        r_tval  <= trap_tval;
`endif
                        r_state <= S_T_MEPC;
                    end else if (mret_req) begin
                        r_state <= S_M_MSTATUS;
                    end
                end
                S_T_MEPC: begin
                    r_mstatus <= mstatus_i;
                    r_state   <= S_T_MCAUSE;
                end
`ifdef TRAP_MTVAL_EN
                S_T_MCAUSE: r_state <= S_T_MTVAL;
                S_T_MTVAL:  r_state <= S_T_MSTATUS;
`else
                S_T_MCAUSE: r_state <= S_T_MSTATUS;
`endif
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    assign pipe_ready    = w_idle;
    assign busy          = !w_idle;
    assign pipe_drop_err = r_drop_err;
    assign trap_ack      = reset_n && w_idle && trap_req;
    assign mret_ack      = reset_n && w_idle && !trap_req && mret_req;
    assign trap_done     = (r_state == S_T_MSTATUS);
    assign mret_done     = (r_state == S_M_MSTATUS);
    assign csr_we        = reset_n && (w_idle ? pipe_csr_we : 1'b1);

    assign csr_addr = w_idle                   ? pipe_csr_addr :
                      (r_state == S_T_MEPC)    ? CSR_MEPC      :
                      (r_state == S_T_MCAUSE)  ? CSR_MCAUSE    :
`ifdef TRAP_MTVAL_EN
                      (r_state == S_T_MTVAL)   ? CSR_MTVAL     :
`endif
                      CSR_MSTATUS;

    assign csr_wdata = w_idle                   ? pipe_csr_wdata            :
                       (r_state == S_T_MEPC)    ? r_epc                     :
                       (r_state == S_T_MCAUSE)  ? r_cause                   :
`ifdef TRAP_MTVAL_EN
                       (r_state == S_T_MTVAL)   ? r_tval                    :
`endif
                       (r_state == S_T_MSTATUS) ? trap_mstatus(r_mstatus)   :
                       mret_mstatus(mstatus_i);

endmodule

// File: tb/tb_trap_csr_sequencer.sv
// tb_trap_csr_sequencer: directed stimulus with a queue-based write model checked every cycle, plus literal expectations
module tb_trap_csr_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pipe_csr_we = 1'b0;
    logic [11:0] pipe_csr_addr = '0;
    logic [31:0] pipe_csr_wdata = '0;
    logic        pipe_ready;
    logic        trap_req = 1'b0;
    logic [31:0] trap_epc = '0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_tval = '0;
    logic        mret_req = 1'b0;
    logic [31:0] mstatus_i = '0;
    logic        trap_ack, mret_ack, trap_done, mret_done;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        busy, pipe_drop_err;

    int n_chk = 0;
    int n_fail = 0;

`ifdef TRAP_MTVAL_EN
    localparam int TLEN = 4;
`else
    localparam int TLEN = 3;
`endif

    trap_csr_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .pipe_csr_we(pipe_csr_we), .pipe_csr_addr(pipe_csr_addr), .pipe_csr_wdata(pipe_csr_wdata),
        .pipe_ready(pipe_ready),
        .trap_req(trap_req), .trap_epc(trap_epc), .trap_cause(trap_cause),
`ifdef TRAP_MTVAL_EN
        .trap_tval(trap_tval),
`endif
        .mret_req(mret_req), .mstatus_i(mstatus_i),
        .trap_ack(trap_ack), .mret_ack(mret_ack), .trap_done(trap_done), .mret_done(mret_done),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .busy(busy), .pipe_drop_err(pipe_drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a queue of the writes still owed by the accepted sequence.
    // kind 0 = literal data, 1 = literal data and take mstatus snapshot,
    // 2 = trap mstatus from snapshot, 3 = mret mstatus from live mstatus_i
    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        int          k;
    } ent_t;

    ent_t        q[$];
    logic        m_drop = 1'b0;
    logic [31:0] m_snap = '0;

    function automatic logic [31:0] m_trap_ms(input logic [31:0] s);
        return (s & ~32'h0000_1888) | ((s & 32'h8) << 4) | 32'h0000_1800;
    endfunction

    function automatic logic [31:0] m_mret_ms(input logic [31:0] s);
        return (s & ~32'h0000_0088) | ((s >> 4) & 32'h8) | 32'h0000_0080;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_csr_we", {31'b0, csr_we}, 32'd0);
            chk("rst_acks", {28'b0, trap_ack, mret_ack, trap_done, mret_done}, 32'd0);
            chk("rst_busy_drop", {30'b0, busy, pipe_drop_err}, 32'd0);
            chk("rst_pipe_ready", {31'b0, pipe_ready}, 32'd1);
            q.delete();
            m_drop = 1'b0;
        end else if (q.size() == 0) begin
            chk("idle_ready", {30'b0, pipe_ready, busy}, 32'd2);
            chk("idle_we", {31'b0, csr_we}, {31'b0, pipe_csr_we});
            if (pipe_csr_we) begin
                chk("idle_addr", {20'b0, csr_addr}, {20'b0, pipe_csr_addr});
                chk("idle_data", csr_wdata, pipe_csr_wdata);
            end
            chk("idle_trap_ack", {31'b0, trap_ack}, {31'b0, trap_req});
            chk("idle_mret_ack", {31'b0, mret_ack}, {31'b0, !trap_req && mret_req});
            chk("idle_dones", {30'b0, trap_done, mret_done}, 32'd0);
            chk("idle_drop", {31'b0, pipe_drop_err}, {31'b0, m_drop});
            if (trap_req) begin
                q.push_back('{12'h341, trap_epc, 1});
                q.push_back('{12'h342, trap_cause, 0});
`ifdef TRAP_MTVAL_EN
                q.push_back('{12'h343, trap_tval, 0});
`endif
                q.push_back('{12'h300, 32'h0, 2});
            end else if (mret_req) begin
                q.push_back('{12'h300, 32'h0, 3});
            end
        end else begin
            ent_t        e;
            logic [31:0] ed;
            e  = q.pop_front();
            ed = (e.k == 2) ? m_trap_ms(m_snap) : (e.k == 3) ? m_mret_ms(mstatus_i) : e.d;
            chk("seq_ready_busy", {30'b0, pipe_ready, busy}, 32'd1);
            chk("seq_we", {31'b0, csr_we}, 32'd1);
            chk("seq_addr", {20'b0, csr_addr}, {20'b0, e.a});
            chk("seq_data", csr_wdata, ed);
            chk("seq_acks", {30'b0, trap_ack, mret_ack}, 32'd0);
            chk("seq_trap_done", {31'b0, trap_done}, {31'b0, e.k == 2});
            chk("seq_mret_done", {31'b0, mret_done}, {31'b0, e.k == 3});
            chk("seq_drop", {31'b0, pipe_drop_err}, {31'b0, m_drop});
            if (e.k == 1) m_snap = mstatus_i;
            if (pipe_csr_we) m_drop = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) step();
        chk("lit_rst_ready", {31'b0, pipe_ready}, 32'd1);
        reset_n = 1'b1;
        step();
        // Trap entry
        mstatus_i = 32'h0000_0008; trap_req = 1'b1; trap_epc = 32'h0000_1004;
        trap_cause = 32'h8000_0007; trap_tval = 32'hDEAD_BEEF;
        #1 chk("lit_trap_ack", {31'b0, trap_ack}, 32'd1);
        step(); trap_req = 1'b0;
        #1 chk("lit_mepc", {19'b0, csr_we, csr_addr}, {19'b0, 1'b1, 12'h341});
        chk("lit_mepc_d", csr_wdata, 32'h0000_1004);
        step();
        #1 chk("lit_mcause", {20'b0, csr_addr}, 32'h342);
        chk("lit_mcause_d", csr_wdata, 32'h8000_0007);
`ifdef TRAP_MTVAL_EN
        step();
        #1 chk("lit_mtval", {20'b0, csr_addr}, 32'h343);
        chk("lit_mtval_d", csr_wdata, 32'hDEAD_BEEF);
`endif
        step();
        #1 chk("lit_tms", {20'b0, csr_addr}, 32'h300);
        chk("lit_tms_d", csr_wdata, 32'h0000_1880);
        chk("lit_tdone", {31'b0, trap_done}, 32'd1);
        step();
        // Mret
        mstatus_i = 32'h0000_1880; mret_req = 1'b1;
        #1 chk("lit_mret_ack", {31'b0, mret_ack}, 32'd1);
        step(); mret_req = 1'b0;
        #1 chk("lit_mms_d", csr_wdata, 32'h0000_1888);
        chk("lit_mdone", {31'b0, mret_done}, 32'd1);
        step();
        // Simultaneous requests plus pipeline write
        trap_req = 1'b1; mret_req = 1'b1; trap_epc = 32'h0000_2000; trap_cause = 32'h0000_000B;
        pipe_csr_we = 1'b1; pipe_csr_addr = 12'h304; pipe_csr_wdata = 32'h80; mstatus_i = 32'h8;
        #1 chk("lit_sim_pipe", {20'b0, csr_addr}, 32'h304);
        chk("lit_sim_pipe_d", csr_wdata, 32'h80);
        chk("lit_sim_acks", {30'b0, trap_ack, mret_ack}, 32'd2);
        step(); trap_req = 1'b0; pipe_csr_we = 1'b0;
        step(); mstatus_i = 32'h0;
        repeat (TLEN - 2) step();
        #1 chk("lit_sim_snap", csr_wdata, 32'h0000_1880);
        step(); mstatus_i = 32'h80;
        #1 chk("lit_sim_mret_ack", {31'b0, mret_ack}, 32'd1);
        step(); mret_req = 1'b0;
        #1 chk("lit_sim_mret_d", csr_wdata, 32'h0000_0088);
        step();
        // Drop while busy
        trap_req = 1'b1;
        step(); trap_req = 1'b0;
        step(); pipe_csr_we = 1'b1; pipe_csr_addr = 12'h305; pipe_csr_wdata = 32'h1234;
        #1 chk("lit_drop_ready", {31'b0, pipe_ready}, 32'd0);
        chk("lit_drop_addr", {20'b0, csr_addr}, 32'h342);
        step(); pipe_csr_we = 1'b0;
        #1 chk("lit_drop_flag", {31'b0, pipe_drop_err}, 32'd1);
        repeat (TLEN + 2) step();
        chk("lit_drop_sticky", {31'b0, pipe_drop_err}, 32'd1);
        // Mid-sequence reset during T_MEPC
        trap_req = 1'b1;
        step(); trap_req = 1'b0; reset_n = 1'b0;
        #1 chk("lit_mr_we", {31'b0, csr_we}, 32'd0);
        chk("lit_mr_busy", {31'b0, busy}, 32'd0);
        chk("lit_mr_drop", {31'b0, pipe_drop_err}, 32'd0);
        step(); reset_n = 1'b1;
        for (int i = 0; i < TLEN + 1; i++) begin
            step();
            chk("lit_mr_nowrite", {31'b0, csr_we}, 32'd0);
        end
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
